// File: rtl/spio_link_pkt_serializer.sv
// Packet-to-flit serializer for the SpiNNaker link: accepts a short/long packet, emits it LSB-first as flits.
// Optional build macro SPIO_PKT_SERIALIZER_PARITY_EN forces header bit 0 to odd packet parity.
module spio_link_pkt_serializer #(
  parameter int unsigned PKT_BITS  = 72,
  parameter int unsigned FLIT_BITS = 8
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  input  logic [PKT_BITS-1:0]  DATA_IN,
  input  logic                 VLD_IN,
  output logic                 RDY_OUT,
  output logic [FLIT_BITS-1:0] FLIT_OUT,
  output logic                 LAST_OUT,
  output logic                 VLD_OUT,
  input  logic                 RDY_IN
);

  localparam int unsigned SHORT_BITS  = 40;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned LONG_FLITS  = PKT_BITS / FLIT_BITS;
  localparam int unsigned SHORT_FLITS = SHORT_BITS / FLIT_BITS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PKT_BITS-1:0]  shreg_q, shreg_d;
  logic [FLIT_BITS-1:0] flit_q, flit_d;
  logic                 last_q, last_d;
  logic                 vld_q, vld_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_idx_q, last_idx_d;

  logic [PKT_BITS-1:0]  pkt_in;
  logic [IDX_W-1:0]     load_last_idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic                 is_long_c;
  logic                 rdy_c;
  logic                 accept_c;
  logic                 consume_c;

  // Packet as it will be transmitted, plus its final flit index
  always_comb begin
    is_long_c = DATA_IN[1];
    pkt_in    = DATA_IN;
`ifdef SPIO_PKT_SERIALIZER_PARITY_EN
    if (is_long_c) begin
      pkt_in[0] = ~(^DATA_IN[PKT_BITS-1:1]);
    end else begin
      pkt_in[0] = ~(^DATA_IN[SHORT_BITS-1:1]);
    end
`endif
    load_last_idx = is_long_c ? IDX_W'(LONG_FLITS - 1) : IDX_W'(SHORT_FLITS - 1);
  end

  // Ready while idle, or when the final flit leaves this cycle (no bubble between packets)
  always_comb begin
    rdy_c     = (state_q == ST_IDLE) || (vld_q && RDY_IN && last_q);
    accept_c  = VLD_IN && rdy_c;
    consume_c = vld_q && RDY_IN;
    idx_nxt   = idx_q + IDX_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    flit_d     = flit_q;
    last_d     = last_q;
    vld_d      = vld_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;

    case (state_q)
      ST_IDLE: begin
        vld_d = 1'b0;
      end
      ST_SEND: begin
        if (consume_c) begin
          if (last_q) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d   = idx_nxt;
            flit_d  = shreg_q[FLIT_BITS-1:0];
            shreg_d = shreg_q >> FLIT_BITS;
            last_d  = (idx_nxt == last_idx_q);
          end
        end
      end
    endcase

    // A new packet overrides the idle return and presents its flit 0 next cycle
    if (accept_c) begin
      state_d    = ST_SEND;
      vld_d      = 1'b1;
      idx_d      = '0;
      last_idx_d = load_last_idx;
      flit_d     = pkt_in[FLIT_BITS-1:0];
      shreg_d    = pkt_in >> FLIT_BITS;
      last_d     = (load_last_idx == '0);
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      flit_q     <= '0;
      last_q     <= 1'b0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      flit_q     <= flit_d;
      last_q     <= last_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign RDY_OUT  = rdy_c;
  assign FLIT_OUT = flit_q;
  assign LAST_OUT = last_q;
  assign VLD_OUT  = vld_q;

endmodule

// File: tb/tb_spio_link_pkt_serializer.sv
// Directed bench for spio_link_pkt_serializer with a flit scoreboard.
module tb_spio_link_pkt_serializer;

  localparam int unsigned PKT_BITS  = 72;
  localparam int unsigned FLIT_BITS = 8;

`ifdef SPIO_PKT_SERIALIZER_PARITY_EN
  localparam logic [7:0] HDR01_FLIT0 = 8'h00;
`else
  localparam logic [7:0] HDR01_FLIT0 = 8'h01;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] data_in;
  logic        vld_in;
  logic        rdy_out;
  logic [7:0]  flit_out;
  logic        last_out;
  logic        vld_out;
  logic        rdy_in;

  typedef struct packed {
    logic [7:0] flit;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  spio_link_pkt_serializer #(
    .PKT_BITS (PKT_BITS),
    .FLIT_BITS(FLIT_BITS)
  ) dut (
    .CLK_IN  (clk),
    .RESET_IN(rst_n),
    .DATA_IN (data_in),
    .VLD_IN  (vld_in),
    .RDY_OUT (rdy_out),
    .FLIT_OUT(flit_out),
    .LAST_OUT(last_out),
    .VLD_OUT (vld_out),
    .RDY_IN  (rdy_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the packet as it should appear on the wire
  function automatic logic [71:0] model_pkt(input logic [71:0] d);
    logic [71:0] m;
    m = d;
`ifdef SPIO_PKT_SERIALIZER_PARITY_EN
    begin
      int   n;
      logic p;
      n = d[1] ? 72 : 40;
      p = 1'b0;
      for (int i = 1; i < n; i++) p = p ^ d[i];
      m[0] = ~p;
    end
`endif
    return m;
  endfunction

  function automatic int nflits(input logic [71:0] d);
    return d[1] ? 9 : 5;
  endfunction

  function automatic logic [7:0] exp_flit(input logic [71:0] d, input int k);
    logic [71:0] m;
    m = model_pkt(d);
    return m[k*8 +: 8];
  endfunction

  task automatic push_pkt(input logic [71:0] d);
    int n;
    n = nflits(d);
    for (int k = 0; k < n; k++) sb.push_back('{flit: exp_flit(d, k), last: (k == n - 1)});
  endtask

  // Offer a packet until accepted; returns at posedge+1 with flit 0 on the outputs
  task automatic send(input string tag, input logic [71:0] d);
    bit ok;
    ok = 1'b0;
    #1;
    data_in = d;
    vld_in  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rdy_out === 1'b1) begin
        push_pkt(d);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    vld_in = 1'b0;
    check({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (vld_out === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every consumed flit is compared with the next expected one
  always @(negedge clk) begin
    if (mon_en && vld_out === 1'b1 && rdy_in === 1'b1) begin
      check("mon_sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("mon_flit", 32'(flit_out), 32'(mon_e.flit));
        check("mon_last", 32'(last_out), 32'(mon_e.last));
      end
    end
  end

  initial begin
    logic [71:0] d1, d2, da, db, d4, d5, d6, d7, d8;
    logic [3:0]  pat;
    int          n;

    d1 = {32'hFFFF_FFFF, 32'h1234_5678, 8'h00};
    d2 = {32'hCAFE_F00D, 32'hDEAD_BEEF, 8'h02};
    da = {32'h1122_3344, 32'h5566_7788, 8'h06};
    db = {32'h99AA_BBCC, 32'hDDEE_FF00, 8'h82};
    d4 = {32'hA5A5_A5A5, 32'h1234_5678, 8'h00};
    d5 = {32'h0102_0304, 32'h0506_0708, 8'h0A};
    d6 = {32'h0000_0000, 32'hCAFE_BABE, 8'h10};
    d7 = {32'h0000_0000, 32'h0000_0001, 8'h00};
    d8 = {32'h0000_0000, 32'h0000_0001, 8'h01};
    pat = 4'b1001;

    rst_n   = 1'b0;
    vld_in  = 1'b0;
    rdy_in  = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", 32'(vld_out), 32'd0);
    check("rst_last", 32'(last_out), 32'd0);
    check("rst_flit", 32'(flit_out), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    rdy_in = 1'b1;
    #1;
    check("rst_rdy_out", 32'(rdy_out), 32'd1);

    // Short packet, upper bits must be ignored
    send("t1", d1);
    check("t1_lat_vld", 32'(vld_out), 32'd1);
    check("t1_flit0", 32'(flit_out), 32'(exp_flit(d1, 0)));
    check("t1_last0", 32'(last_out), 32'd0);
    check("t1_rdy_busy", 32'(rdy_out), 32'd0);
    wait_idle(n);
    check("t1_len", 32'(n), 32'd5);

    // Long packet
    send("t2", d2);
    check("t2_flit0", 32'(flit_out), 32'(exp_flit(d2, 0)));
    wait_idle(n);
    check("t2_len", 32'(n), 32'd9);

    // Back-to-back long packets
    send("t3a", da);
    data_in = db;
    vld_in  = 1'b1;
    for (int c = 0; c < 9; c++) begin
      check("t3_vld", 32'(vld_out), 32'd1);
      check("t3_rdy_out", 32'(rdy_out), 32'(c == 8));
      if (c == 8 && rdy_out === 1'b1) push_pkt(db);
      @(posedge clk);
      #1;
    end
    vld_in = 1'b0;
    check("t3_b_flit0", 32'(flit_out), 32'(exp_flit(db, 0)));
    wait_idle(n);
    check("t3_b_len", 32'(n), 32'd9);

    // Backpressure 1,0,0,1 with a bogus offer that must be ignored
    send("t4", d4);
    data_in = {32'hDEAD_DEAD, 32'hBEEF_BEEF, 8'h02};
    vld_in  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rdy_in = pat[c];
      #1;
      check("t4_rdy_out", 32'(rdy_out), 32'd0);
      check("t4_vld", 32'(vld_out), 32'd1);
      check("t4_last", 32'(last_out), 32'd0);
      if (c > 0) check("t4_hold", 32'(flit_out), 32'h78);
      @(posedge clk);
      #1;
    end
    vld_in = 1'b0;
    rdy_in = 1'b1;
    check("t4_flit2", 32'(flit_out), 32'h56);
    wait_idle(n);
    check("t4_rest_len", 32'(n), 32'd3);

    // Reset while flit 3 of a long packet is pending
    send("t5", d5);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t5_flit3", 32'(flit_out), 32'(exp_flit(d5, 3)));
    rdy_in = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_vld", 32'(vld_out), 32'd0);
    check("t5_rst_last", 32'(last_out), 32'd0);
    check("t5_rst_flit", 32'(flit_out), 32'd0);
    check("t5_sb_left", 32'(sb.size()), 32'd6);
    sb.delete();
    rst_n  = 1'b1;
    rdy_in = 1'b1;
    #1;
    check("t5_rdy_out", 32'(rdy_out), 32'd1);
    send("t5b", d6);
    check("t5b_flit0", 32'(flit_out), 32'(exp_flit(d6, 0)));
    wait_idle(n);
    check("t5b_len", 32'(n), 32'd5);

    // Header bit 0 handling
    send("t6a", d7);
    check("t6_hdr00", 32'(flit_out), 32'h00);
    wait_idle(n);
    check("t6a_len", 32'(n), 32'd5);
    send("t6b", d8);
    check("t6_hdr01", 32'(flit_out), 32'(HDR01_FLIT0));
    wait_idle(n);
    check("t6b_len", 32'(n), 32'd5);

    repeat (2) @(posedge clk);
    #1;
    check("end_sb_empty", 32'(sb.size()), 32'd0);
    check("end_vld", 32'(vld_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spio_link_pkt_serializer.md
SPIO_LINK_PKT_SERIALIZER -- requirements
Module: spio_link_pkt_serializer

Interface
REQ-001 SHALL have parameter PKT_BITS, default 72, meaning the packet width (header [7:0], key [39:8], payload [71:40]).
REQ-002 SHALL have parameter FLIT_BITS, default 8, meaning the output flit width; PKT_BITS and 40 SHALL be multiples of FLIT_BITS.
REQ-003 SHALL have port CLK_IN, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_IN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port DATA_IN, input, PKT_BITS bits: the packet from the upstream rdy/vld source (the slow-clock side of the link speed halver).
REQ-006 SHALL have port VLD_IN, input, 1 bit: DATA_IN is valid.
REQ-007 SHALL have port RDY_OUT, output, 1 bit: a packet is accepted when VLD_IN && RDY_OUT.
REQ-008 SHALL have port FLIT_OUT, output, FLIT_BITS bits: the current flit, registered.
REQ-009 SHALL have port LAST_OUT, output, 1 bit: the current flit is the final flit of its packet, registered.
REQ-010 SHALL have port VLD_OUT, output, 1 bit: FLIT_OUT is valid, registered.
REQ-011 SHALL have port RDY_IN, input, 1 bit: a flit is consumed when VLD_OUT && RDY_IN.

Function
REQ-012 SHALL classify a packet as long when header bit 1 (DATA_IN[1]) = 1 (9 flits at FLIT_BITS=8), otherwise short (40 bits, 5 flits); the flit count is latched at acceptance.
REQ-013 SHALL emit flits LSB first: flit k = pkt[k*FLIT_BITS +: FLIT_BITS].
REQ-014 SHALL run a two-state FSM: IDLE (VLD_OUT=0) and SEND (VLD_OUT=1).
REQ-015 SHALL drive RDY_OUT combinationally as (state==IDLE) || (VLD_OUT && RDY_IN && LAST_OUT), so back-to-back packets produce no bubble.
REQ-016 SHALL, on acceptance, latch the packet into an internal shift register and present flit 0 with VLD_OUT=1 on the next cycle (latency 1 cycle), entering SEND.
REQ-017 SHALL hold FLIT_OUT, LAST_OUT and VLD_OUT stable while VLD_OUT && !RDY_IN.
REQ-018 SHALL, on each consumed non-final flit, advance to the next flit and increment the 4-bit flit index.
REQ-019 SHALL assert LAST_OUT exactly when index = flit count - 1.
REQ-020 SHALL, on a consumed final flit with no simultaneous acceptance, return to IDLE with VLD_OUT=0 next cycle.
REQ-021 SHALL, on a consumed final flit with a simultaneous acceptance, present flit 0 of the new packet next cycle and remain in SEND.
REQ-022 SHALL ignore DATA_IN and VLD_IN whenever RDY_OUT=0.
REQ-023 SHALL never deassert VLD_OUT before the flit has been consumed.

Reset
REQ-024 SHALL, on a clock edge with RESET_IN=0, set state IDLE, VLD_OUT=0, LAST_OUT=0, FLIT_OUT=0 and index 0, with RDY_OUT=1 from the first cycle after release.
REQ-025 SHALL, if reset occurs mid-packet, discard the remaining flits; no partial packet SHALL be resumed.

Configuration
REQ-026 SHALL, with macro SPIO_PKT_SERIALIZER_PARITY_EN defined, replace header bit 0 of each accepted packet with odd parity computed over the other bits of the packet (39 bits short, 71 bits long), so the transmitted packet has odd overall parity.
REQ-027 SHALL, without SPIO_PKT_SERIALIZER_PARITY_EN, transmit header bit 0 unmodified and contain no parity logic.

Verification
REQ-028 SHALL cover a short packet: DATA_IN[39:0]=40'h1234_5678_00 with RDY_IN=1 -> flits 00,78,56,34,12 on consecutive cycles, with LAST_OUT only on 12 and the first flit one cycle after acceptance.
REQ-029 SHALL cover a long packet: header 8'h02, key 32'hDEADBEEF, payload 32'hCAFEF00D -> 9 flits 02,EF,BE,AD,DE,0D,F0,FE,CA, with LAST_OUT on CA.
REQ-030 SHALL cover back-to-back traffic: two long packets with VLD_IN and RDY_IN held at 1 -> 18 flits on 18 consecutive cycles, RDY_OUT=1 on the cycle of flit 9, and no bubble.
REQ-031 SHALL cover backpressure: RDY_IN toggled 1,0,0,1 during a short packet -> the flit is held stable across the stalls, no flit is lost or duplicated, and RDY_OUT=0 throughout.
REQ-032 SHALL cover reset mid-packet: RESET_IN=0 for 1 cycle after flit 3 -> VLD_OUT=0 next cycle, and a new short packet then starts at flit 0.
REQ-033 SHALL cover parity with the macro defined: short packet, header 8'h00, key 32'h00000001 -> transmitted flit 0 = 8'h00; with header 8'h01 supplied -> flit 0 = 8'h00.
